br_dump_reader: RTL and testbench
=================================

// Module: br_dump_reader
// PURPOSE
//   Read-side companion to the BR register bank. On a start pulse it walks
//   every BR register through read ports a1/a2, two registers per capture.
//   It streams each value out as a valid/ready word tagged with its index.
//   Used for debug dumps and end-of-test register checks.
// PARAMETERS
//   NREG  32  number of registers to dump; must be even and >= 2
//   AW     5  address width; 2**AW >= NREG
//   DW    32  data width
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   begin dump; sampled only in IDLE
//   abort       in   1   synchronous cancel; flushes the dump, no done pulse
//   a1          out  AW  BR read address 1 (even index)
//   a2          out  AW  BR read address 2 (odd index)
//   rd1         in   DW  BR read data for a1; combinational, valid same cycle
//   rd2         in   DW  BR read data for a2; combinational, valid same cycle
//   dout_valid  out  1   output word valid
//   dout_ready  in   1   consumer accepts the word
//   dout_data   out  DW  register value
//   dout_addr   out  AW  register index of dout_data
//   dout_last   out  1   high with the word for index NREG-1
//   busy        out  1   dump in progress
//   done        out  1   one-cycle pulse after the last word's handshake
// BEHAVIOUR
//   Reset (async, any state): FSM=IDLE; ptr=0; 2-entry FIFO empty.
//     Output reset values: a1=0, a2=1, dout_valid=0, dout_data=0,
//     dout_addr=0, dout_last=0, busy=0, done=0.
//   Addressing: a1=ptr, a2=ptr+1; both are driven from the registered ptr.
//   FSM states:
//     IDLE: start=1 -> READ; ptr=0.
//     READ: capture = (cnt==0) || (cnt==1 && pop).
//       On capture: push {rd1,ptr} then {rd2,ptr+1} in that order; ptr+=2.
//       If the captured ptr+1 == NREG-1, go to DRAIN.
//     DRAIN: FIFO empties through the output; the last pop -> DONE.
//     DONE: done=1 for one cycle -> IDLE; ptr=0.
//   Pop: a pop occurs when dout_valid && dout_ready.
//     dout_* show the FIFO head; dout_valid = (cnt!=0).
//     While valid && !ready, dout_data/addr/last are held stable.
//     A pop and a push in the same cycle are legal; cnt updates by net change.
//   Latency: start sampled at edge T -> READ at T+1 -> dout_valid at T+2
//     carrying addr 0. Steady state with ready=1 gives one word per cycle.
//   Output order: words emerge in strictly increasing addr, 0..NREG-1.
//     Each index is emitted exactly once.
//   busy = (state != IDLE) && (state != DONE).
//   start while busy is ignored. start and abort together in IDLE: abort wins.
//   abort in READ/DRAIN: next cycle IDLE; FIFO flushed; ptr=0;
//     dout_valid=0; done stays 0.
//   rd1/rd2 are captured raw; register-0 semantics are owned by BR.
//   BR writes during a dump are permitted. The captured value is the one
//     BR presents in the capture cycle.
// TESTING
//   1. Preload BankReg[0..3]=01230000/01231111/01232222/01233333, rest k;
//      start, ready=1 -> addr 0..31 in order with those values,
//      first valid at start+2, last=1 only at addr 31, done one cycle later.
//   2. Toggle ready 1,0,0,1,... -> no word lost or duplicated;
//      data/addr hold while stalled; the 32-word sequence matches test 1.
//   3. ready=0 from start -> cnt saturates at 2 (words 0 and 1);
//      a1/a2 stay at 2/3 until the first pop.
//   4. abort after 5 pops -> busy=0 and dout_valid=0 next cycle, no done;
//      a fresh start then dumps again from addr 0.
//   5. rst_n low mid-dump (asynchronous, between edges) -> outputs take
//      their reset values immediately; start during busy has no effect.
//   6. NREG=4 build -> exactly 4 words; done pulses once; returns to IDLE.

Source files
------------

// File: rtl/br_dump_reader.sv
// Streams every BR register out as an index-tagged valid/ready word, reading two
// registers per capture through ports a1/a2 into a two-entry output FIFO.
module br_dump_reader #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned DW   = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic [AW-1:0] a1,
   output logic [AW-1:0] a2,
   input  logic [DW-1:0] rd1,
   input  logic [DW-1:0] rd2,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout_data,
   output logic [AW-1:0] dout_addr,
   output logic          dout_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

   state_e        state_q;
   logic [AW-1:0] ptr_q;
   logic [1:0]    cnt_q;
   logic [DW-1:0] head_data_q, tail_data_q;
   logic [AW-1:0] head_addr_q, tail_addr_q;
   logic          head_last_q, tail_last_q;
   logic          busy_q, done_q;

   logic [AW-1:0] ptr_odd;
   logic          pop;
   logic          capture;

   assign ptr_odd    = ptr_q + AW'(1);
   assign dout_valid = (cnt_q != 2'd0);
   assign pop        = dout_valid && dout_ready;
   // A capture only happens when the FIFO is empty after this cycle's pop,
   // so both new words always land in head/tail together.
   assign capture    = (state_q == StRead) &&
                       ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         cnt_q       <= 2'd0;
         head_data_q <= '0;
         tail_data_q <= '0;
         head_addr_q <= '0;
         tail_addr_q <= '0;
         head_last_q <= 1'b0;
         tail_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start && !abort) begin
                  state_q <= StRead;
                  busy_q  <= 1'b1;
                  ptr_q   <= '0;
               end
            end
            StRead, StDrain: begin
               if (abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  cnt_q   <= 2'd0;
                  ptr_q   <= '0;
               end else if (capture) begin
                  head_data_q <= rd1;
                  head_addr_q <= ptr_q;
                  head_last_q <= 1'b0;
                  tail_data_q <= rd2;
                  tail_addr_q <= ptr_odd;
                  tail_last_q <= (ptr_odd == LastIdx);
                  cnt_q       <= 2'd2;
                  ptr_q       <= ptr_q + AW'(2);
                  if (ptr_odd == LastIdx) begin
                     state_q <= StDrain;
                  end
               end else if (pop) begin
                  head_data_q <= tail_data_q;
                  head_addr_q <= tail_addr_q;
                  head_last_q <= tail_last_q;
                  cnt_q       <= cnt_q - 2'd1;
                  if ((state_q == StDrain) && (cnt_q == 2'd1)) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               ptr_q   <= '0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign a1        = ptr_q;
   assign a2        = ptr_odd;
   assign dout_data = head_data_q;
   assign dout_addr = head_addr_q;
   assign dout_last = head_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_br_dump_reader.sv
// Scoreboard bench: expected words are queued at start, monitors pop and compare
// on every presented word for a 32-register and a 4-register build.
module tb_br_dump_reader;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, dout_ready;
   logic [4:0]  a1, a2, dout_addr;
   logic [31:0] rd1, rd2, dout_data;
   logic        dout_valid, dout_last, busy, done;

   logic        start4, ready4;
   logic [1:0]  a1_4, a2_4, dout_addr4;
   logic [31:0] rd1_4, rd2_4, dout_data4;
   logic        dout_valid4, dout_last4, busy4, done4;

   logic [31:0] bank [32];
   word_t       q[$];
   word_t       q4[$];
   int          n_vec = 0, n_err = 0, n_pop = 0, n_done = 0, n_done4 = 0;
   logic        pend_done = 1'b0;

   always #5 clk = ~clk;

   assign rd1   = bank[a1];
   assign rd2   = bank[a2];
   assign rd1_4 = bank[{3'b000, a1_4}];
   assign rd2_4 = bank[{3'b000, a2_4}];

   br_dump_reader #(.NREG(32), .AW(5), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a1(a1), .a2(a2),
      .rd1(rd1), .rd2(rd2), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_data(dout_data), .dout_addr(dout_addr), .dout_last(dout_last),
      .busy(busy), .done(done)
   );

   br_dump_reader #(.NREG(4), .AW(2), .DW(32)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(1'b0), .a1(a1_4), .a2(a2_4),
      .rd1(rd1_4), .rd2(rd2_4), .dout_valid(dout_valid4), .dout_ready(ready4),
      .dout_data(dout_data4), .dout_addr(dout_addr4), .dout_last(dout_last4),
      .busy(busy4), .done(done4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int i);
      case (i)
         0:       return 32'h0123_0000;
         1:       return 32'h0123_1111;
         2:       return 32'h0123_2222;
         3:       return 32'h0123_3333;
         default: return 32'(i);
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_valid) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_word: got addr %0d, expected none", dout_addr);
            end else begin
               check("word_addr", 64'(dout_addr), 64'(q[0].addr));
               check("word_data", 64'(dout_data), 64'(q[0].data));
               check("word_last", 64'(dout_last), 64'(q[0].last));
               if (dout_ready) begin
                  void'(q.pop_front());
                  n_pop++;
               end
            end
         end
         if (done || pend_done) check("done_timing", 64'(done), 64'(pend_done));
         if (done) n_done++;
         pend_done = dout_valid && dout_ready && dout_last;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_valid4) begin
            if (q4.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_word4: got addr %0d, expected none", dout_addr4);
            end else begin
               check("word4_addr", 64'(dout_addr4), 64'(q4[0].addr));
               check("word4_data", 64'(dout_data4), 64'(q4[0].data));
               check("word4_last", 64'(dout_last4), 64'(q4[0].last));
               if (ready4) void'(q4.pop_front());
            end
         end
         if (done4) n_done4++;
      end
   end

   // Pulses start, queues the full expected dump and checks the two-cycle latency.
   task automatic start_dump();
      for (int i = 0; i < 32; i++) q.push_back('{addr: 5'(i), data: exp_data(i), last: (i == 31)});
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("latency_valid_T", 64'(dout_valid), 64'd0);
      check("busy_after_start", 64'(busy), 64'd1);
      @(posedge clk); #1;
      check("latency_valid_T1", 64'(dout_valid), 64'd1);
      check("first_addr", 64'(dout_addr), 64'd0);
   endtask

   // pat 0: ready always high; pat 1: ready 1,0,0,1 with a stray start mid-dump.
   task automatic finish_dump(input int pat);
      int d0;
      logic ok;
      d0 = n_done;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (pat == 0) dout_ready = 1'b1;
         else          dout_ready = ((c % 4) == 0) || ((c % 4) == 3);
         start = (pat == 1) && (c == 10);
         @(posedge clk); #1;
         start = 1'b0;
         if (q.size() == 0 && n_done > d0) begin
            ok = 1'b1;
            break;
         end
      end
      check("dump_complete", 64'(ok), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("done_count", 64'(n_done - d0), 64'd1);
      check("idle_after_dump", 64'(busy), 64'd0);
   endtask

   initial begin
      int p0, d0;
      logic ok;
      for (int i = 0; i < 32; i++) bank[i] = exp_data(i);
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
      start4 = 1'b0; ready4 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_a1", 64'(a1), 64'd0);
      check("rst_a2", 64'(a2), 64'd1);
      check("rst_valid", 64'(dout_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // Full dump, ready always high.
      dout_ready = 1'b1;
      start_dump();
      finish_dump(0);

      // Ready toggling plus an ignored start while busy.
      start_dump();
      finish_dump(1);

      // Ready held low: FIFO fills with words 0/1 and the read pointer parks at 2.
      dout_ready = 1'b0;
      start_dump();
      repeat (4) @(posedge clk);
      #1;
      check("stall_a1", 64'(a1), 64'd2);
      check("stall_a2", 64'(a2), 64'd3);
      check("stall_valid", 64'(dout_valid), 64'd1);
      finish_dump(0);

      // Abort after five pops, then a fresh dump.
      dout_ready = 1'b1;
      d0 = n_done;
      start_dump();
      p0 = n_pop;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (n_pop - p0 >= 5) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("abort_reach_5", 64'(ok), 64'd1);
      abort = 1'b1;
      dout_ready = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_valid", 64'(dout_valid), 64'd0);
      check("abort_a1", 64'(a1), 64'd0);
      q.delete();
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 64'(n_done - d0), 64'd0);
      dout_ready = 1'b1;
      start_dump();
      finish_dump(0);

      // Asynchronous reset between edges mid-dump.
      start_dump();
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("areset_a1", 64'(a1), 64'd0);
      check("areset_a2", 64'(a2), 64'd1);
      check("areset_valid", 64'(dout_valid), 64'd0);
      check("areset_data", 64'(dout_data), 64'd0);
      check("areset_addr", 64'(dout_addr), 64'd0);
      check("areset_last", 64'(dout_last), 64'd0);
      check("areset_busy", 64'(busy), 64'd0);
      check("areset_done", 64'(done), 64'd0);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Four-register build.
      for (int i = 0; i < 4; i++) q4.push_back('{addr: 5'(i), data: exp_data(i), last: (i == 3)});
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (q4.size() == 0 && n_done4 > 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("n4_complete", 64'(ok), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check("n4_done_count", 64'(n_done4), 64'd1);
      check("n4_idle", 64'(busy4), 64'd0);
      check("n4_no_valid", 64'(dout_valid4), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
